// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device-side transmitter.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_START_BIT  = 0;
    localparam int PS2_STOP_BIT   = 1;
    localparam int PS2_GAP_HALVES = 2;

    // Frame laid out LSB-first: bit 0 goes on the wire first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'(PS2_STOP_BIT), ~^b, b, 1'(PS2_START_BIT)};
    endfunction
endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte handshake plus PS/2 pin bundle between a byte producer and ps2_device_tx.
interface ps2_device_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_data;

    modport master (output tx_data, tx_valid, input tx_ready, busy, ps2_clk, ps2_data);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, ps2_clk, ps2_data);
endinterface

// File: rtl/ps2_tx_fifo.sv
// Small byte FIFO with full/empty flags; a push while full is taken only alongside a pop.
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host frame generator (drives both ps2_clk and ps2_data).
// Define PS2_TX_FIFO_EN to put a 4-entry byte FIFO in front of the serializer.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500
) (
    input logic           clk,
    input logic           rst,
    ps2_device_tx_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    ps2_state_e                state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      half_q, half_d;
    logic [PS2_FRAME_BITS-1:0] sh_q, sh_d;
    logic                      clk_q, clk_d, dat_q, dat_d;
    logic                      load;
    logic [7:0]                load_byte;
    logic                      phase_end;

`ifdef PS2_TX_FIFO_EN
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    assign bus.tx_ready = !fifo_full;
    assign load         = (state_q == IDLE) && !fifo_empty;
    assign load_byte    = fifo_dout;

    ps2_tx_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (bus.tx_valid && !fifo_full),
        .data_i (bus.tx_data),
        .pop_i  (load),
        .data_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );
`else
    assign bus.tx_ready = (state_q == IDLE);
    assign load         = bus.tx_valid && (state_q == IDLE);
    assign load_byte    = bus.tx_data;
`endif

    assign phase_end    = (cnt_q == CNT_LAST);
    assign bus.busy     = (state_q != IDLE);
    assign bus.ps2_clk  = clk_q;
    assign bus.ps2_data = dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            sh_q    <= '1;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sh_q    <= sh_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        half_d  = half_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (load) begin
                    state_d = BIT_HI;
                    idx_d   = '0;
                    sh_d    = ps2_frame(load_byte);
                end
            end
            BIT_HI: if (phase_end) begin
                state_d = BIT_LO;
                cnt_d   = '0;
            end
            BIT_LO: if (phase_end) begin
                cnt_d = '0;
                if (idx_q < 4'(PS2_FRAME_BITS - 1)) begin
                    state_d = BIT_HI;
                    idx_d   = idx_q + 4'd1;
                    sh_d    = {1'b1, sh_q[PS2_FRAME_BITS-1:1]};
                end else begin
                    state_d = GAP;
                    half_d  = 1'b0;
                end
            end
            GAP: if (phase_end) begin
                cnt_d = '0;
                // The gap is counted in half-bit phases so the divider stays CLK_DIV wide.
                if (half_q == 1'(PS2_GAP_HALVES - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data only moves on entry to BIT_HI, so it is stable across every clock fall.
    always_comb begin
        clk_d = (state_d != BIT_LO);
        dat_d = 1'b1;
        if (state_d == BIT_HI || state_d == BIT_LO) dat_d = sh_d[0];
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// Randomized bench for ps2_device_tx with a timeline-based frame model and literal frame checks.
module tb_ps2_device_tx;
    localparam int D = 4;
    localparam int FRAME_CYC = 24 * D;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    ps2_device_tx_if bus();

    ps2_device_tx #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: a frame is a timeline t = 0 .. 24*D-1 after the start bit appears.
    logic       m_active;
    int         m_t;
    logic [7:0] m_byte;
    logic [7:0] mq[$];
    logic       m_push;
    logic       fe_q[$];
    int         busy_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void exp_pins(output logic c, output logic d);
        int b;
        c = 1'b1;
        d = 1'b1;
        if (m_active) begin
            b = m_t / (2 * D);
            if (b < 11) begin
                c = (m_t % (2 * D)) < D;
                if (b == 0)      d = 1'b0;
                else if (b <= 8) d = m_byte[b-1];
                else if (b == 9) d = ~^m_byte;
                else             d = 1'b1;
            end
        end
    endfunction

    function automatic logic exp_ready();
`ifdef PS2_TX_FIFO_EN
        return mq.size() < 4;
`else
        return !m_active;
`endif
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 1'b0;
            m_t = 0;
            mq.delete();
        end else begin
`ifdef PS2_TX_FIFO_EN
            m_push = bus.tx_valid && (mq.size() < 4);
            if (!m_active && mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_active = 1'b1;
                m_t = 0;
            end else if (m_active) begin
                m_t++;
                if (m_t == FRAME_CYC) m_active = 1'b0;
            end
            if (m_push) mq.push_back(bus.tx_data);
`else
            if (!m_active && bus.tx_valid) begin
                m_byte = bus.tx_data;
                m_active = 1'b1;
                m_t = 0;
            end else if (m_active) begin
                m_t++;
                if (m_t == FRAME_CYC) m_active = 1'b0;
            end
`endif
        end
    end

    initial forever begin
        logic c, d;
        @(negedge clk);
        if (!rst) begin
            exp_pins(c, d);
            check("ps2_clk", 32'(bus.ps2_clk), 32'(c));
            check("ps2_data", 32'(bus.ps2_data), 32'(d));
            check("busy", 32'(bus.busy), 32'(m_active));
            check("tx_ready", 32'(bus.tx_ready), 32'(exp_ready()));
            if (bus.busy) busy_cnt++;
        end
    end

    initial forever begin
        @(negedge bus.ps2_clk);
        if (!rst) fe_q.push_back(bus.ps2_data);
    end

    task automatic send(input logic [7:0] b);
        int   n = 0;
        logic acc = 1'b0;
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        while (!acc && n < 3000) begin
            acc = bus.tx_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        if (!acc) check("send_timeout", 32'(n), 32'd0);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            quiet = bus.busy ? 0 : quiet + 1;
        end
        if (n >= 5000) check("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_frame(input string name, input logic [10:0] f);
        check({name, "_edges"}, 32'(fe_q.size()), 32'd11);
        for (int i = 0; i < 11 && i < fe_q.size(); i++)
            check(name, 32'(fe_q[i]), 32'(f[i]));
    endtask

    initial begin
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_ps2_clk", 32'(bus.ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(bus.ps2_data), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        rst = 1'b0;

        fe_q.delete();
        busy_cnt = 0;
        send(8'h1C);
        wait_idle();
        check_frame("frame_1c", 11'b100_0011_1000);
        check("busy_cycles_1c", 32'(busy_cnt), 32'd96);

        fe_q.delete();
        send(8'h00);
        wait_idle();
        check_frame("frame_00", 11'b110_0000_0000);

        fe_q.delete();
        send(8'hFF);
        wait_idle();
        check_frame("frame_ff", 11'b111_1111_1110);

        // A second byte is held while the first is on the wire.
        send(8'h1C);
        send(8'h32);
        wait_idle();

        send(8'hF0);
        send(8'h1C);
        send(8'h32);
        send(8'h23);
        send(8'h24);
        wait_idle();

        // Land inside d5 (half-bit phases 12..13 of the frame), then reset.
        send(8'h55);
        repeat (50) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ps2_clk", 32'(bus.ps2_clk), 32'd1);
        check("midrst_ps2_data", 32'(bus.ps2_data), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        fe_q.delete();
        send(8'h1C);
        wait_idle();
        check_frame("post_rst_1c", 11'b100_0011_1000);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send(8'($urandom));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
